// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and key-map helpers for the keypad scanner.
// Code space: 0..9 digits, 10 '*', 11 '#', 14 several keys, 15 no key.
package keypad_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_PROX  = 4'd11;
    localparam logic [3:0] KEY_MULTI = 4'd14;
    localparam logic [3:0] KEY_NONE  = 4'd15;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLD
    } state_e;

    // Matrix position to key code.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_CLEAR;
                2'd1:    code = 4'd0;
                default: code = KEY_PROX;
            endcase
        end else begin
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    // Reduce a full-scan press vector (bit = row*3 + col) to a single code.
    function automatic logic [3:0] scan_decode(input logic [NUM_KEYS-1:0] vec);
        logic [3:0] code;
        int hits;
        code = KEY_NONE;
        hits = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (vec[i]) begin
                hits++;
                code = key_map(2'(i / NUM_COLS), 2'(i % NUM_COLS));
            end
        end
        if (hits > 1) begin
            code = KEY_MULTI;
        end
        return code;
    endfunction

    // One-hot strobe vector: bits 0..9 digits, bit 10 clear, bit 11 prox.
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [3:0] code);
        return (code <= KEY_PROX) ? (12'd1 << code) : 12'd0;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs; both stages reset high
// so idle active-low lines read as inactive straight out of reset.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row drive, column sync, per-scan decode, debounce,
// and a one-event-per-press strobe generator feeding the detector inputs.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned PULSE_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row_n,
    input  logic [2:0] col_n,
    output logic [0:9] io,
    output logic       clear,
    output logic       prox,
    output logic [3:0] key_code
);

    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_SCANS);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

    // ------------------------------------------------------------------
    // Column synchronizer
    // ------------------------------------------------------------------
    logic [2:0] col_sync;

    sync2 #(
        .WIDTH(3)
    ) u_col_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (col_n),
        .q    (col_sync)
    );

    // ------------------------------------------------------------------
    // Row scan and press-vector accumulation
    // ------------------------------------------------------------------
    logic [1:0]          row;
    logic [1:0]          row_next;
    logic [SW-1:0]       slot;
    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] vec_full;
    logic                sample;
    logic                scan_end;
    logic [3:0]          scan_code;

    // Sampling on the last slot cycle gives the row time to settle and the
    // synchronizer time to pass the response through.
    always_comb begin
        sample   = (slot == SLOT_LAST);
        scan_end = sample && (row == 2'd3);
        row_next = sample ? row + 2'd1 : row;
        vec_full = press_vec;
        if (sample) begin
            unique case (row)
                2'd0: vec_full[2:0]   = press_vec[2:0]   | ~col_sync;
                2'd1: vec_full[5:3]   = press_vec[5:3]   | ~col_sync;
                2'd2: vec_full[8:6]   = press_vec[8:6]   | ~col_sync;
                2'd3: vec_full[11:9]  = press_vec[11:9]  | ~col_sync;
            endcase
        end
        scan_code = scan_decode(vec_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= 2'd0;
            slot      <= '0;
            row_n     <= 4'b1110;
            press_vec <= '0;
        end else begin
            slot      <= sample ? '0 : slot + 1'b1;
            row       <= row_next;
            row_n     <= ~(4'b0001 << row_next);
            press_vec <= scan_end ? '0 : vec_full;
        end
    end

    // ------------------------------------------------------------------
    // Scan-to-scan debounce
    // ------------------------------------------------------------------
    logic [3:0]    prev_code;
    logic [3:0]    stable;
    logic [MW-1:0] match_cnt;
    logic [MW-1:0] match_next;

    always_comb begin
        match_next = match_cnt;
        if (scan_code == prev_code) begin
            if (match_cnt != MATCH_MAX) begin
                match_next = match_cnt + 1'b1;
            end
        end else begin
            match_next = MW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_code <= KEY_NONE;
            match_cnt <= '0;
            stable    <= KEY_NONE;
        end else if (scan_end) begin
            prev_code <= scan_code;
            match_cnt <= match_next;
            if (match_next == MATCH_MAX) begin
                stable <= scan_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FSM with registered strobes
    // ------------------------------------------------------------------
    state_e              state;
    logic [3:0]          code;
    logic [PW-1:0]       pulse_cnt;
    logic [NUM_KEYS-1:0] strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            code      <= KEY_NONE;
            key_code  <= KEY_NONE;
            pulse_cnt <= '0;
            strobe    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (stable <= KEY_PROX) begin
                        state     <= PULSE;
                        code      <= stable;
                        key_code  <= stable;
                        pulse_cnt <= PULSE_LOAD;
                        strobe    <= key_onehot(stable);
                    end else if (stable == KEY_MULTI) begin
                        state <= HOLD;
                    end
                end
                PULSE: begin
                    if (pulse_cnt == PW'(1)) begin
                        state  <= HOLD;
                        strobe <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                        strobe    <= key_onehot(code);
                    end
                end
                // A new event needs a debounced release first: no repeat, no roll-over.
                HOLD: begin
                    if (stable == KEY_NONE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    strobe <= '0;
                end
            endcase
        end
    end

    for (genvar d = 0; d < 10; d++) begin : g_io
        assign io[d] = strobe[d];
    end
    assign clear = strobe[10];
    assign prox  = strobe[11];

endmodule
